// File: rtl/snn_pkg.sv
// Shared fixed-point definitions for the spiking-neuron blocks: Q0.16 per-tick
// probability format and window-count to rate conversion.
package snn_pkg;

  localparam int Q16_W = 16;
  localparam logic [Q16_W-1:0] Q16_MAX = 16'hFFFF;

  // total spikes over a 2^win_log2 window -> Q0.16 probability, saturating at 1.0
  function automatic logic [Q16_W-1:0] sat_shift_q16(input logic [16:0] total,
                                                     input int win_log2);
    logic [32:0] wide;
    wide = 33'(total) << (Q16_W - win_log2);
    if (wide > 33'(Q16_MAX)) return Q16_MAX;
    return wide[Q16_W-1:0];
  endfunction

endpackage

// File: rtl/isi_meter.sv
// Inter-spike interval meter: counts enabled ticks since the last spike and
// reports the interval, saturating, on every spike after the first.
module isi_meter #(
  parameter int ISI_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic [ISI_W-1:0] cnt;
  logic             seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      seen      <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (en) begin
        if (spike) begin
          // cnt restarts at 0 so the next spike reports cnt+1 enabled ticks
          cnt  <= '0;
          seen <= 1'b1;
          if (seen) begin
            isi       <= (cnt == ISI_MAX) ? ISI_MAX : cnt + ISI_W'(1);
            isi_valid <= 1'b1;
          end
        end else if (cnt != ISI_MAX) begin
          cnt <= cnt + ISI_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train rate decoder: counts spikes over a 2^WIN_LOG2 enabled-tick window,
// reports count and Q0.16 rate with valid/ready handshake, and measures ISI.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WIN_LOG2 = 10,
  parameter int ISI_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                spike,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WIN_LOG2:0]   count,
  output logic [Q16_W-1:0]    rate_q16,
  output logic                overrun,
  output logic [ISI_W-1:0]    isi,
  output logic                isi_valid
);

  logic [WIN_LOG2-1:0] tick_cnt;
  logic [WIN_LOG2:0]   acc;
  logic [WIN_LOG2:0]   total;
  logic                final_tick;
  logic                handshake;

  assign final_tick = en && (&tick_cnt);
  assign total      = acc + (WIN_LOG2+1)'(spike);
  assign handshake  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      rate_q16  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (en) begin
        tick_cnt <= tick_cnt + WIN_LOG2'(1);
        acc      <= final_tick ? '0 : total;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      // a new result wins over the consume; only an unaccepted one counts as overrun
      if (final_tick) begin
        count     <= total;
        rate_q16  <= sat_shift_q16(17'(total), WIN_LOG2);
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end
    end
  end

  isi_meter #(
    .ISI_W(ISI_W)
  ) u_isi_meter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spike    (spike),
    .isi      (isi),
    .isi_valid(isi_valid)
  );

endmodule
